// File: rtl/cacheline_adapter_pkg.sv
// Shared definitions for the cache-line to memory-burst adapter.
package cacheline_adapter_pkg;

    // Adapter control states.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } adapter_state_e;

    // Default geometry: a 256-bit line moved as four 64-bit beats.
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;

endpackage

// File: rtl/cacheline_adapter.sv
// Cache-line adapter: assembles a line fill from memory beats and serialises
// a line writeback into memory beats. Beat 0 is the least significant slice.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int LINE_W   = cacheline_adapter_pkg::LINE_W,
    parameter int BURST_W  = cacheline_adapter_pkg::BURST_W,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] line_address_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [BURST_W-1:0] mem_wdata_o,
    input  logic [BURST_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_e    state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LINE_W-1:0] line_buf;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              resp_q;

    // The line offset bits are dropped on purpose: bursts are always line aligned.
    logic addr_offset_unused;
    assign addr_offset_unused = ^line_address_i[OFFSET_W-1:0];

    assign line_rdata_o  = line_buf;
    assign line_resp_o   = resp_q;
    assign mem_address_o = addr_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign mem_wdata_o   = line_buf[beat_cnt*BURST_W +: BURST_W];

    // Control FSM, beat counter, line buffer and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            line_buf    <= '0;
            addr_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            resp_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Writeback wins when both requests arrive together.
                    if (line_write_i) begin
                        state       <= WRITE_BURST;
                        addr_q      <= {line_address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        beat_cnt    <= '0;
                        line_buf    <= line_wdata_i;
                        mem_write_q <= 1'b1;
                    end else if (line_read_i) begin
                        state      <= READ_BURST;
                        addr_q     <= {line_address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        beat_cnt   <= '0;
                        mem_read_q <= 1'b1;
                    end
                end
                READ_BURST: begin
                    if (mem_resp_i) begin
                        line_buf[beat_cnt*BURST_W +: BURST_W] <= mem_rdata_i;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= DONE;
                            mem_read_q <= 1'b0;
                            resp_q     <= 1'b1;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (mem_resp_i) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state       <= DONE;
                            mem_write_q <= 1'b0;
                            resp_q      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    resp_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed vector table, random
// transactions against a transaction-level model, and a mid-burst reset.
module tb_cacheline_adapter;

    localparam int NBEATS = 4;

    logic         clk;
    logic         rst;
    logic [31:0]  line_address_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  mem_address_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    int total = 0;
    int bad   = 0;

    cacheline_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .line_address_i (line_address_i),
        .line_read_i    (line_read_i),
        .line_write_i   (line_write_i),
        .line_wdata_i   (line_wdata_i),
        .line_rdata_o   (line_rdata_o),
        .line_resp_o    (line_resp_o),
        .mem_address_o  (mem_address_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_resp_i     (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               rd;
        bit               wr;
        logic [31:0]      addr;
        logic [255:0]     wdata;
        logic [3:0][63:0] rbeat;     // memory read data, beat k at index k
        logic [3:0][3:0]  gaps;      // idle mem_resp_i cycles before beat k
        logic [31:0]      exp_addr;
        logic [255:0]     exp_line;  // line_rdata_o once the transaction ends
        logic [3:0][63:0] exp_wbeat; // required mem_wdata_o per beat
        bit               exp_write;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Transaction-level model: a request becomes a line-aligned burst; a read
    // yields the beats stacked lowest-first, a write emits the line's 64-bit
    // slices lowest-first and leaves the line in the buffer.
    function automatic vec_t model(input bit rd, input bit wr, input logic [31:0] addr,
                                   input logic [255:0] wdata, input logic [3:0][63:0] rbeat,
                                   input logic [3:0][3:0] gaps);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.rbeat = rbeat; v.gaps = gaps;
        v.exp_addr  = addr - (addr % 32);
        v.exp_write = wr;
        v.exp_line  = 256'd0;
        for (int k = 0; k < NBEATS; k++) begin
            v.exp_wbeat[k] = 64'((wdata >> (64 * k)) & {192'd0, {64{1'b1}}});
            if (wr) v.exp_line = wdata;
            else    v.exp_line = v.exp_line + (256'(rbeat[k]) << (64 * k));
        end
        return v;
    endfunction

    // Drive one transaction from IDLE through DONE and two IDLE cycles,
    // with spurious mem_resp_i during DONE and IDLE.
    task automatic run_vec(input vec_t v);
        int cyc;
        int gsum;
        cyc  = 0;
        gsum = 0;
        line_read_i    = v.rd;
        line_write_i   = v.wr;
        line_address_i = v.addr;
        line_wdata_i   = v.wdata;
        mem_resp_i     = 1'b0;
        tick(); cyc++;
        chk("accept_addr", mem_address_o, v.exp_addr);
        for (int k = 0; k < NBEATS; k++) begin
            for (int g = 0; g < int'(v.gaps[k]); g++) begin
                mem_resp_i  = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
                chk("gap_flags", {mem_read_o, mem_write_o}, {!v.exp_write, v.exp_write});
                chk("gap_resp", line_resp_o, 1'b0);
                tick(); cyc++; gsum++;
            end
            chk("beat_flags", {mem_read_o, mem_write_o}, {!v.exp_write, v.exp_write});
            chk("beat_resp", line_resp_o, 1'b0);
            if (v.exp_write) chk("wbeat", mem_wdata_o, v.exp_wbeat[k]);
            mem_resp_i  = 1'b1;
            mem_rdata_i = v.rbeat[k];
            tick(); cyc++;
        end
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("done_resp", line_resp_o, 1'b1);
        chk("done_flags", {mem_read_o, mem_write_o}, 2'b00);
        chk("latency", cyc + 1, NBEATS + 2 + gsum);
        chk("done_line", line_rdata_o, v.exp_line);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        tick();
        chk("idle_resp", line_resp_o, 1'b0);
        chk("idle_flags", {mem_read_o, mem_write_o}, 2'b00);
        chk("idle_line", line_rdata_o, v.exp_line);
        tick();
        chk("idle2_flags", {mem_read_o, mem_write_o, line_resp_o}, 3'b000);
        chk("idle2_line", line_rdata_o, v.exp_line);
        mem_resp_i = 1'b0;
    endtask

    vec_t table_v [4];

    initial begin
        rst            = 1'b0;
        line_address_i = '0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        line_wdata_i   = '0;
        mem_rdata_i    = '0;
        mem_resp_i     = 1'b0;

        // Directed vectors with hand-computed expectations.
        table_v[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wdata: 256'd0,
            rbeat: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            gaps: 16'h0000, exp_addr: 32'h0000_1220,
            exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            exp_wbeat: '0, exp_write: 1'b0};
        table_v[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_ABCD,
            wdata: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            rbeat: '0, gaps: 16'h0000, exp_addr: 32'h0000_ABC0,
            exp_line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            exp_wbeat: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            exp_write: 1'b1};
        // Gapped read: resp pattern 1,0,0,1,1,0,1.
        table_v[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF, wdata: 256'd0,
            rbeat: {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                    64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
            gaps: 16'h1020, exp_addr: 32'hFFFF_FFE0,
            exp_line: {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                       64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
            exp_wbeat: '0, exp_write: 1'b0};
        // Simultaneous read and write: the write must run.
        table_v[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h8000_0040,
            wdata: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
            rbeat: {4{64'hFFFF_0000_FFFF_0000}}, gaps: 16'h0101, exp_addr: 32'h8000_0040,
            exp_line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
            exp_wbeat: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                        64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
            exp_write: 1'b1};

        // Reset state.
        @(negedge clk);
        chk("rst_outputs", {line_rdata_o, line_resp_o, mem_read_o, mem_write_o}, '0);
        chk("rst_addr", mem_address_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 64'h0);

        // Spurious mem_resp_i in IDLE right after reset.
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_spurious", {line_rdata_o, line_resp_o, mem_read_o, mem_write_o}, '0);
        mem_resp_i = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(table_v[i]);

        // Reset in the middle of a read, after two beats.
        line_read_i    = 1'b1;
        line_address_i = 32'h0000_2000;
        tick();
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'h7777_7777_7777_7777;
        tick();
        mem_rdata_i = 64'h8888_8888_8888_8888;
        tick();
        mem_resp_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_ctrl", {line_resp_o, mem_read_o, mem_write_o}, 3'b000);
        chk("midrst_line", line_rdata_o, 256'd0);
        chk("midrst_addr", mem_address_o, 32'h0);
        chk("midrst_wdata", mem_wdata_o, 64'h0);
        line_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("postrst_idle", {line_rdata_o, line_resp_o, mem_read_o, mem_write_o}, '0);
        run_vec(model(1'b1, 1'b0, 32'h0000_2010, 256'd0,
                      {64'h4D4D_4D4D_4D4D_4D4D, 64'h3C3C_3C3C_3C3C_3C3C,
                       64'h2B2B_2B2B_2B2B_2B2B, 64'h1A1A_1A1A_1A1A_1A1A}, 16'h0000));

        // Random transactions checked against the model.
        for (int n = 0; n < 24; n++) begin
            bit               rd;
            bit               wr;
            logic [3:0][63:0] rb;
            logic [3:0][3:0]  gp;
            logic [1:0]       kind;
            kind = 2'($urandom_range(1, 3));
            rd = kind[0];
            wr = kind[1];
            for (int k = 0; k < NBEATS; k++) begin
                rb[k] = {$urandom, $urandom};
                gp[k] = 4'($urandom_range(0, 2));
            end
            run_vec(model(rd, wr, $urandom, rand_line(), rb, gp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
